seq_layer: RTL and testbench
============================

Name: seq_layer

Overview:
- Sequential, parametrised successor to the combinational digit-classifier layer.
- Takes an N_IN-bit binary pixel vector and computes N_OUT neuron scores, each a bias plus the signed weights of the set pixels.
- Outputs the argmax index as `predict`.
- Weights and biases are runtime-programmable through a config write port.
- Computation runs over multiple cycles under a start/busy/valid handshake.
- Sits between the pixel source (switches or bench) and the display/LED logic on the de10-nano design.

Parameters:
- N_IN, 20, input vector width (pixels).
- N_OUT, 10, neuron/class count.
- W_WIDTH, 8, signed weight and bias width.
- ACC_WIDTH, 14, signed accumulator width; must be ≥ W_WIDTH + clog2(N_IN+1).
- IDX_WIDTH, 4, predict width; must be ≥ clog2(N_OUT).
- ADDR_WIDTH, 8, config address width; must be ≥ clog2(N_OUT*N_IN + N_OUT).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- x  in  N_IN  pixel vector; sampled only on an accepted start.
- start  in  1  request inference.
- busy  out  1  high while computing.
- valid  out  1  high while predict holds a result.
- predict  out  IDX_WIDTH  winning class index.
- cfg_we  in  1  config write enable.
- cfg_addr  in  ADDR_WIDTH  config address.
- cfg_data  in  W_WIDTH  signed weight or bias value.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, busy=0, valid=0, predict=0, accumulators=0. Weight and bias storage is NOT cleared. Reset mid-computation aborts with no valid pulse.
- Config memory map:
  - addr o*N_IN+i (o<N_OUT, i<N_IN) writes weight w[o][i].
  - addr N_OUT*N_IN+o writes bias b[o].
  - Out-of-range addresses are ignored.
  - Writes are ignored while busy=1. A write in the same edge as an accepted start is applied and not seen by that inference.
- FSM states: IDLE, ACC, ARGMAX, DONE.
- Start acceptance: start is accepted only in IDLE or DONE. At accepting edge E0: x_reg<=x, acc[o]<=sign-extend(b[o]), i<=0, valid<=0, busy<=1, state->ACC. Start is ignored in ACC and ARGMAX.
- ACC, edges E1..E_N_IN: for all o in parallel, acc[o] += x_reg[i] ? sign-extend(w[o][i]) : 0. Then i++. x bit i maps to weight column i, with bit 0 the LSB. After i=N_IN-1 the state goes to ARGMAX with k=0.
- ARGMAX, edges E_{N_IN+1}..E_{N_IN+N_OUT}:
  - k=0 loads best=acc[0], idx=0.
  - k>0 replaces when acc[k] > best (strict signed compare), so ties go to the lowest index.
  - After k=N_OUT-1 the state goes to DONE.
- Result edge E_{N_IN+N_OUT+1}: predict<=idx, valid<=1, busy<=0.
- Latency: N_IN+N_OUT+1 edges from start to valid (31 with defaults).
- DONE: valid and predict hold until the next accepted start or reset. A start in DONE is accepted exactly as in IDLE, and valid drops at E0.
- Arithmetic: two's-complement and wrapping. No saturation or overflow flag; parameter constraints prevent overflow.

Optional Feature:
- SEQ_LAYER_SCORE_OUT_EN defined:
  - Adds output port `score` (ACC_WIDTH, signed): the winning accumulator value.
  - Updated together with predict; reset 0.
- Undefined: the port does not exist and no extra registers are built.

Decomposition:
- Shared header seq_layer_defs.vh holds:
  - FSM state encodings (IDLE=0, ACC=1, ARGMAX=2, DONE=3).
  - Default parameter constants.
  - Config address-base macro for biases.
- One sub-module, seq_layer_mem: the weight/bias register file with the config write decode and gating by busy.
  - It exposes column i of all N_OUT weights plus all biases combinationally.
- The FSM, accumulators and argmax stay in seq_layer.

Test Plan:
- All weights 0, b[3]=5, other biases 0; start with x=20'h00000 -> valid rises exactly 31 cycles after start, predict=3, busy low at the same edge.
- Identity weights (w[o][o]=1, else 0), biases 0, x=20'h00080 -> predict=7. Then x=20'h00001 -> predict=0.
- All weights and biases 0 (full tie) -> predict=0. Biases b[0]=-1, others -2 -> predict=0. b[9]=127, others -128 -> predict=9.
- Start pulsed again at cycle 10 of a running inference, and cfg_we writing b[0]=100 while busy -> both ignored; result equals the undisturbed run and b[0] keeps its old value.
- rst_n=0 for one cycle mid-ACC -> busy=0, valid=0, predict=0 next cycle, no valid pulse. A fresh start then gives the pre-reset-programmed result, proving weights were retained.
- With SEQ_LAYER_SCORE_OUT_EN, identity weights, b[o]=o, x=20'h00004 -> predict=9, score=9 (ties to lowest: acc[2]=3 < 9).

Source files
------------

// File: rtl/seq_layer_pkg.sv
// ============================================================================
// Module : seq_layer_pkg
// Brief  : Shared FSM encodings, default parameters and config-map helpers
//          for the sequential classifier layer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package seq_layer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACC    = 2'd1;
    localparam logic [1:0] ST_ARGMAX = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int DEF_N_IN       = 20;
    localparam int DEF_N_OUT      = 10;
    localparam int DEF_W_WIDTH    = 8;
    localparam int DEF_ACC_WIDTH  = 14;
    localparam int DEF_IDX_WIDTH  = 4;
    localparam int DEF_ADDR_WIDTH = 8;

    // Biases sit directly after the N_OUT x N_IN weight block.
    function automatic int bias_base(input int n_in, input int n_out);
        return n_out * n_in;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_layer_mem.sv
// ============================================================================
// Module : seq_layer_mem
// Brief  : Weight/bias register file with config write decode; exposes one
//          weight column for all neurons plus every bias combinationally.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module seq_layer_mem
    import seq_layer_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int N_OUT      = DEF_N_OUT,
    parameter int W_WIDTH    = DEF_W_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SEL_W      = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_busy,
    input  logic                     i_start_acc,
    input  logic                     i_commit,
    input  logic                     i_cfg_we,
    input  logic [ADDR_WIDTH-1:0]    i_cfg_addr,
    input  logic [W_WIDTH-1:0]       i_cfg_data,
    input  logic [SEL_W-1:0]         i_col_sel,
    output logic [N_OUT*W_WIDTH-1:0] o_col,
    output logic [N_OUT*W_WIDTH-1:0] o_bias
);

    localparam int c_BIAS_BASE = bias_base(N_IN, N_OUT);

    logic [W_WIDTH-1:0]    r_w [N_OUT][N_IN];
    logic [W_WIDTH-1:0]    r_b [N_OUT];

    logic                  r_pend_v;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [W_WIDTH-1:0]    r_pend_data;

    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [W_WIDTH-1:0]    w_wr_data;

    // A write landing on the start edge is parked so the running inference
    // never sees it; it retires at the result edge (or on reset).
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = i_cfg_addr;
        w_wr_data = i_cfg_data;
        if (r_pend_v && (i_commit || !rst_n)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_pend_addr;
            w_wr_data = r_pend_data;
        end else if (i_cfg_we && !i_busy && !i_start_acc) begin
            w_wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_v <= 1'b0;
        end else if (i_cfg_we && !i_busy && i_start_acc) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= i_cfg_addr;
            r_pend_data <= i_cfg_data;
        end else if (i_commit) begin
            r_pend_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int o = 0; o < N_OUT; o++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (w_wr_addr == ADDR_WIDTH'(o * N_IN + i))
                        r_w[o][i] <= w_wr_data;
                end
                if (w_wr_addr == ADDR_WIDTH'(c_BIAS_BASE + o))
                    r_b[o] <= w_wr_data;
            end
        end
    end

    generate
        for (genvar o = 0; o < N_OUT; o++) begin : g_out
            assign o_col[o*W_WIDTH +: W_WIDTH]  = r_w[o][i_col_sel];
            assign o_bias[o*W_WIDTH +: W_WIDTH] = r_b[o];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/seq_layer.sv
// ============================================================================
// Module : seq_layer
// Brief  : Sequential classifier layer: per-pixel accumulate, then argmax.
//          Optional `score` output enabled by SEQ_LAYER_SCORE_OUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module seq_layer
    import seq_layer_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int N_OUT      = DEF_N_OUT,
    parameter int W_WIDTH    = DEF_W_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       x,
    input  logic                  start,
    output logic                  busy,
    output logic                  valid,
    output logic [IDX_WIDTH-1:0]  predict,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [W_WIDTH-1:0]    cfg_data
`ifdef SEQ_LAYER_SCORE_OUT_EN
    ,
    output logic signed [ACC_WIDTH-1:0] score
`endif
);

    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [1:0]                  r_state;
    logic                        r_busy;
    logic                        r_valid;
    logic [IDX_WIDTH-1:0]        r_predict;
    logic [N_IN-1:0]             r_x;
    logic [SEL_W-1:0]            r_i;
    logic [IDX_WIDTH-1:0]        r_k;
    logic signed [ACC_WIDTH-1:0] r_acc [N_OUT];
    logic signed [ACC_WIDTH-1:0] r_best;
    logic [IDX_WIDTH-1:0]        r_idx;

    logic                        w_start_acc;
    logic                        w_result;
    logic [N_OUT*W_WIDTH-1:0]    w_col;
    logic [N_OUT*W_WIDTH-1:0]    w_bias;
    logic signed [ACC_WIDTH-1:0] w_add  [N_OUT];
    logic signed [ACC_WIDTH-1:0] w_bext [N_OUT];
    logic signed [ACC_WIDTH-1:0] w_acc_k;

    // DONE is entered with busy still high; the first DONE cycle publishes.
    assign w_start_acc = rst_n && start &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE && r_valid));
    assign w_result    = (r_state == ST_DONE) && !r_valid;
    assign w_acc_k     = r_acc[r_k];

    seq_layer_mem #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .W_WIDTH    (W_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SEL_W      (SEL_W)
    ) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_busy      (r_busy),
        .i_start_acc (w_start_acc),
        .i_commit    (w_result),
        .i_cfg_we    (cfg_we),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_data  (cfg_data),
        .i_col_sel   (r_i),
        .o_col       (w_col),
        .o_bias      (w_bias)
    );

    generate
        for (genvar o = 0; o < N_OUT; o++) begin : g_ext
            logic [W_WIDTH-1:0] w_wv;
            logic [W_WIDTH-1:0] w_bv;
            assign w_wv      = w_col[o*W_WIDTH +: W_WIDTH];
            assign w_bv      = w_bias[o*W_WIDTH +: W_WIDTH];
            assign w_add[o]  = r_x[r_i] ? {{(ACC_WIDTH-W_WIDTH){w_wv[W_WIDTH-1]}}, w_wv}
                                        : '0;
            assign w_bext[o] = {{(ACC_WIDTH-W_WIDTH){w_bv[W_WIDTH-1]}}, w_bv};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_predict <= '0;
            r_x       <= '0;
            r_i       <= '0;
            r_k       <= '0;
            r_best    <= '0;
            r_idx     <= '0;
            for (int o = 0; o < N_OUT; o++) r_acc[o] <= '0;
        end else if (w_start_acc) begin
            r_x     <= x;
            r_i     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_ACC;
            for (int o = 0; o < N_OUT; o++) r_acc[o] <= w_bext[o];
        end else begin
            case (r_state)
                ST_ACC: begin
                    for (int o = 0; o < N_OUT; o++) r_acc[o] <= r_acc[o] + w_add[o];
                    if (r_i == SEL_W'(N_IN - 1)) begin
                        r_state <= ST_ARGMAX;
                        r_k     <= '0;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                ST_ARGMAX: begin
                    if (r_k == '0) begin
                        r_best <= w_acc_k;
                        r_idx  <= '0;
                    end else if (w_acc_k > r_best) begin
                        r_best <= w_acc_k;
                        r_idx  <= r_k;
                    end
                    if (r_k == IDX_WIDTH'(N_OUT - 1)) r_state <= ST_DONE;
                    else                              r_k     <= r_k + 1'b1;
                end
                ST_DONE: begin
                    if (!r_valid) begin
                        r_predict <= r_idx;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_LAYER_SCORE_OUT_EN
    logic signed [ACC_WIDTH-1:0] r_score;

    always_ff @(posedge clk) begin
        if (!rst_n)        r_score <= '0;
        else if (w_result) r_score <= r_best;
    end

    assign score = r_score;
`endif

    assign busy    = r_busy;
    assign valid   = r_valid;
    assign predict = r_predict;

endmodule

`default_nettype wire

// File: tb/tb_seq_layer.sv
// ============================================================================
// Module : tb_seq_layer
// Brief  : Directed, table-driven bench for seq_layer (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_layer;

    localparam int N_IN  = 20;
    localparam int N_OUT = 10;
    localparam int W     = 8;
    localparam int ACC   = 14;
    localparam int IDX   = 4;
    localparam int AW    = 8;
    localparam int LAT   = N_IN + N_OUT + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_IN-1:0] x;
    logic            start;
    logic            busy;
    logic            valid;
    logic [IDX-1:0]  predict;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [W-1:0]    cfg_data;
`ifdef SEQ_LAYER_SCORE_OUT_EN
    logic signed [ACC-1:0] score;
`endif

    always #5 clk = ~clk;

    seq_layer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_WIDTH(W),
        .ACC_WIDTH(ACC), .IDX_WIDTH(IDX), .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .start    (start),
        .busy     (busy),
        .valid    (valid),
        .predict  (predict),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data)
`ifdef SEQ_LAYER_SCORE_OUT_EN
        ,
        .score    (score)
`endif
    );

    typedef struct {
        int              wmode;   // 0 zero, 1 identity, 2 negative identity
        logic [79:0]     bias;
        logic [N_IN-1:0] xv;
        int              exp;
    } vec_t;

    vec_t vecs [10];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] wval(input int mode, input int o, input int i);
        if (o != i)    return 8'h00;
        if (mode == 1) return 8'h01;
        if (mode == 2) return 8'hFF;
        return 8'h00;
    endfunction

    function automatic logic [79:0] mkb(input int def, input int idx, input int val);
        logic [79:0] b;
        for (int o = 0; o < N_OUT; o++) b[o*8 +: 8] = 8'((o == idx) ? val : def);
        return b;
    endfunction

    task automatic program_mem(input int mode, input logic [79:0] b);
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                cfg_we = 1'b1; cfg_addr = AW'(o * N_IN + i); cfg_data = wval(mode, o, i);
                tick();
            end
        end
        for (int o = 0; o < N_OUT; o++) begin
            cfg_we = 1'b1; cfg_addr = AW'(N_OUT * N_IN + o); cfg_data = b[o*8 +: 8];
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int cyc0, input int exp);
        int cyc = cyc0;
        while (!valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check({name, " latency"}, cyc, LAT);
        check({name, " busy@valid"}, int'(busy), 0);
        check({name, " predict"}, int'(predict), exp);
    endtask

    task automatic run(input string name, input logic [N_IN-1:0] xv, input int exp);
        x = xv; start = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy@E0"}, int'(busy), 1);
        check({name, " valid@E0"}, int'(valid), 0);
        wait_valid(name, 0, exp);
    endtask

    initial begin
        logic seen_valid;

        vecs[0] = '{0, mkb(0, 3, 5),       20'h00000, 3};
        vecs[1] = '{1, mkb(0, -1, 0),      20'h00080, 7};
        vecs[2] = '{1, mkb(0, -1, 0),      20'h00001, 0};
        vecs[3] = '{0, mkb(0, -1, 0),      20'hFFFFF, 0};
        vecs[4] = '{0, mkb(-2, 0, -1),     20'h00000, 0};
        vecs[5] = '{0, mkb(-128, 9, 127),  20'h00000, 9};
        vecs[6] = '{2, mkb(0, -1, 0),      20'h00001, 1};
        vecs[7] = '{1, mkb(0, -1, 0),      20'h00200, 9};
        vecs[8] = '{1, mkb(0, -1, 0),      20'hFFFFF, 0};
        vecs[9] = '{2, mkb(0, -1, 0),      20'h003FD, 1};

        rst_n = 1'b0; x = '0; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        check("reset busy",    int'(busy),    0);
        check("reset valid",   int'(valid),   0);
        check("reset predict", int'(predict), 0);

        for (int v = 0; v < 10; v++) begin
            program_mem(vecs[v].wmode, vecs[v].bias);
            run($sformatf("vec%0d", v), vecs[v].xv, vecs[v].exp);
        end

        // Start re-pulse and a bias write at cycle 10 must both be ignored.
        program_mem(1, mkb(0, -1, 0));
        x = 20'h00080; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        x = 20'h00001; start = 1'b1;
        cfg_we = 1'b1; cfg_addr = AW'(N_OUT * N_IN); cfg_data = 8'd100;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        wait_valid("disturb", 10, 7);
        run("b0_kept", 20'h00002, 1);

        // Reset mid-ACC aborts; weights survive.
        run("pre_rst", 20'h00080, 7);
        x = 20'h00080; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst busy",    int'(busy),    0);
        check("midrst valid",   int'(valid),   0);
        check("midrst predict", int'(predict), 0);
        seen_valid = 1'b0;
        repeat (40) begin
            tick();
            if (valid) seen_valid = 1'b1;
        end
        check("midrst no valid", int'(seen_valid), 0);
        run("post_rst", 20'h00080, 7);

`ifdef SEQ_LAYER_SCORE_OUT_EN
        begin
            logic [79:0] ramp;
            for (int o = 0; o < N_OUT; o++) ramp[o*8 +: 8] = 8'(o);
            program_mem(1, ramp);
            run("score_run", 20'h00004, 9);
            check("score value", int'(score), 9);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
